pc_alu_core: RTL

PC_ALU_CORE -- requirements
Module: pc_alu_core

---
 rtl/core_pkg.sv | 31 +++
 rtl/core_alu.sv | 48 ++++
 rtl/pc_alu_core.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types for the PC/ALU core: opcode and FSM state enumerations.
package core_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_JZ   = 3'b110,
    OP_HALT = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // True for every state in which the core is running a program.
  function automatic logic is_busy_state(input state_e s);
    return (s != ST_IDLE) && (s != ST_HALT);
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU: unsigned, truncated to DATA_W. Control opcodes (JZ, HALT)
// yield a zero result that the core never commits.
module core_alu
  import core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // Operation select; carry holds carry-out for ADD and borrow for SUB.
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        result = sum_s[DATA_W-1:0];
        carry  = sum_s[DATA_W];
      end
      OP_SUB: begin
        result = diff_s[DATA_W-1:0];
        carry  = diff_s[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b[SH_W-1:0];
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/pc_alu_core.sv
// Multi-cycle PC + ALU core driving an external synchronous ROM.
// Each instruction takes FETCH, DECODE, EXEC and WB (4 cycles).
// Optional macro CORE_TRACE_EN adds a simulation-only binary trace per EXEC.
module pc_alu_core
  import core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [OP_W+2*DATA_W-1:0] ins,
  output logic [ADDR_W-1:0]        dir,
  output logic [OP_W-1:0]          op,
  output logic [DATA_W-1:0]        A,
  output logic [DATA_W-1:0]        B,
  output logic [DATA_W-1:0]        resultado,
  output logic                     zero,
  output logic                     carry,
  output logic                     busy,
  output logic                     done
);

  localparam int INS_W = OP_W + 2*DATA_W;

  state_e              state_q, state_d;
  logic [INS_W-1:0]    ins_q, ins_d;
  logic [ADDR_W-1:0]   dir_q, dir_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [OP_W-1:0]     dec_op_s;
  logic [DATA_W-1:0]   dec_a_s;
  logic [DATA_W-1:0]   dec_b_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic                alu_zero_s;
  logic                alu_carry_s;

  assign dec_op_s = ins_q[INS_W-1 -: OP_W];
  assign dec_a_s  = ins_q[2*DATA_W-1 -: DATA_W];
  assign dec_b_s  = ins_q[DATA_W-1:0];

  core_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (dec_op_s),
    .a      (dec_a_s),
    .b      (dec_b_s),
    .result (alu_res_s),
    .zero   (alu_zero_s),
    .carry  (alu_carry_s)
  );

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    dir_d   = dir_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d   = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        ins_d   = ins;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        op_d = dec_op_s;
        a_d  = dec_a_s;
        b_d  = dec_b_s;
        case (op_e'(dec_op_s))
          OP_JZ:   state_d = ST_WB;
          OP_HALT: begin
            done_d  = 1'b1;
            state_d = ST_HALT;
          end
          default: begin
            res_d   = alu_res_s;
            zero_d  = alu_zero_s;
            carry_d = alu_carry_s;
            state_d = ST_WB;
          end
        endcase
      end
      ST_WB: begin
        if ((op_e'(op_q) == OP_JZ) && zero_q) begin
          dir_d = b_q[ADDR_W-1:0];
        end else begin
          dir_d = dir_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          dir_d   = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = is_busy_state(state_d);
  end

  // State and output registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ins_q   <= '0;
      dir_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      dir_q   <= dir_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CORE_TRACE_EN
  // Simulation-only trace of each executed instruction and its committed result.
  always_ff @(posedge clk) begin
    if (reset && (state_q == ST_EXEC)) begin
      $display("%b %b %b %b %b", ins_q, dec_op_s, dec_a_s, dec_b_s, res_d);
    end
  end
`endif

  assign dir       = dir_q;
  assign op        = op_q;
  assign A         = a_q;
  assign B         = b_q;
  assign resultado = res_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
